// File: rtl/brisc_pkg.sv
// Shared types and constants for the brisc memory subsystem.
// Also holds the line-alignment helper used by everything that talks to main memory.
package brisc_pkg;

    localparam int unsigned ADDRESS_BITS     = 32'd32;
    localparam int unsigned CACHE_LINE_LEN   = 32'd128;
    localparam int unsigned BYTE_LEN         = 32'd8;
    localparam int unsigned LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);

    localparam logic [ADDRESS_BITS-1:0] LINE_ADDR_MASK =
        {{(ADDRESS_BITS - LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};
    localparam logic [CACHE_LINE_LEN-1:0] LINE_ZERO = {CACHE_LINE_LEN{1'b0}};

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } arb_owner_e;

    function automatic logic [ADDRESS_BITS-1:0] line_align(input logic [ADDRESS_BITS-1:0] addr);
        return addr & LINE_ADDR_MASK;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: req[0] is the I-side, req[1] the D-side.
// On contention the requester that did not win last time is chosen.
module rr_arb2
    import brisc_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_e last_owner,
    output arb_owner_e winner
);

    // Winner is only meaningful when at least one request is high
    always_comb begin
        winner = OWNER_IC;
        case (req)
            2'b01:   winner = OWNER_IC;
            2'b10:   winner = OWNER_DC;
            2'b11:   winner = (last_owner == OWNER_IC) ? OWNER_DC : OWNER_IC;
            default: winner = OWNER_IC;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between I-cache and D-cache, one line
// transaction at a time, round-robin on contention. All outputs are registered.
module mem_arbiter
    import brisc_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ic_req_i,
    input  logic [ADDRESS_BITS-1:0]   ic_addr_i,
    output logic                      ic_gnt_o,
    output logic                      ic_valid_o,
    output logic [CACHE_LINE_LEN-1:0] ic_rdata_o,
    input  logic                      dc_req_i,
    input  logic                      dc_we_i,
    input  logic [ADDRESS_BITS-1:0]   dc_addr_i,
    input  logic [CACHE_LINE_LEN-1:0] dc_wdata_i,
    output logic                      dc_gnt_o,
    output logic                      dc_valid_o,
    output logic [CACHE_LINE_LEN-1:0] dc_rdata_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDRESS_BITS-1:0]   mem_addr_o,
    output logic [CACHE_LINE_LEN-1:0] mem_wdata_o,
    input  logic                      mem_ready_i,
    input  logic                      mem_valid_i,
    input  logic [CACHE_LINE_LEN-1:0] mem_rdata_i
);

    arb_state_e                state_q, state_d;
    arb_owner_e                owner_q, owner_d;
    arb_owner_e                last_owner_q, last_owner_d;
    arb_owner_e                winner_s;
    logic [ADDRESS_BITS-1:0]   addr_q, addr_d;
    logic                      we_q, we_d;
    logic [CACHE_LINE_LEN-1:0] wdata_q, wdata_d;
    logic [CACHE_LINE_LEN-1:0] line_q, line_d;
    logic                      mem_req_q, mem_req_d;
    logic                      ic_gnt_q, ic_gnt_d, dc_gnt_q, dc_gnt_d;
    logic                      ic_valid_q, ic_valid_d, dc_valid_q, dc_valid_d;
    logic                      any_req_s;

    assign any_req_s = ic_req_i | dc_req_i;

    rr_arb2 u_rr_arb2 (
        .req        ({dc_req_i, ic_req_i}),
        .last_owner (last_owner_q),
        .winner     (winner_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory handshakes are only looked at in their own state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (any_req_s)   state_d = ARB_REQ;  else state_d = ARB_IDLE;
            ARB_REQ:  if (mem_ready_i) state_d = ARB_WAIT; else state_d = ARB_REQ;
            ARB_WAIT: if (mem_valid_i) state_d = ARB_RESP; else state_d = ARB_WAIT;
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Next values of the registered outputs and latched transaction fields
    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        line_d       = line_q;
        mem_req_d    = mem_req_q;
        ic_gnt_d     = 1'b0;
        dc_gnt_d     = 1'b0;
        ic_valid_d   = 1'b0;
        dc_valid_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req_s) begin
                    owner_d      = winner_s;
                    last_owner_d = winner_s;
                    mem_req_d    = 1'b1;
                    if (winner_s == OWNER_DC) begin
                        addr_d   = line_align(dc_addr_i);
                        we_d     = dc_we_i;
                        wdata_d  = dc_we_i ? dc_wdata_i : LINE_ZERO;
                        dc_gnt_d = 1'b1;
                    end else begin
                        addr_d   = line_align(ic_addr_i);
                        we_d     = 1'b0;
                        wdata_d  = LINE_ZERO;
                        ic_gnt_d = 1'b1;
                    end
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            ARB_REQ: begin
                if (mem_ready_i) mem_req_d = 1'b0; else mem_req_d = 1'b1;
            end
            ARB_WAIT: begin
                if (mem_valid_i) begin
                    line_d     = we_q ? LINE_ZERO : mem_rdata_i;
                    ic_valid_d = (owner_q == OWNER_IC);
                    dc_valid_d = (owner_q == OWNER_DC);
                end else begin
                    line_d = line_q;
                end
            end
            // Clearing the line here keeps rdata at zero outside the valid pulse
            ARB_RESP: line_d = LINE_ZERO;
            default: begin
                line_d    = LINE_ZERO;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Transaction and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWNER_IC;
            last_owner_q <= OWNER_IC;
            addr_q       <= {ADDRESS_BITS{1'b0}};
            we_q         <= 1'b0;
            wdata_q      <= LINE_ZERO;
            line_q       <= LINE_ZERO;
            mem_req_q    <= 1'b0;
            ic_gnt_q     <= 1'b0;
            dc_gnt_q     <= 1'b0;
            ic_valid_q   <= 1'b0;
            dc_valid_q   <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
            mem_req_q    <= mem_req_d;
            ic_gnt_q     <= ic_gnt_d;
            dc_gnt_q     <= dc_gnt_d;
            ic_valid_q   <= ic_valid_d;
            dc_valid_q   <= dc_valid_d;
        end
    end

    assign ic_gnt_o    = ic_gnt_q;
    assign dc_gnt_o    = dc_gnt_q;
    assign ic_valid_o  = ic_valid_q;
    assign dc_valid_o  = dc_valid_q;
    assign ic_rdata_o  = line_q;
    assign dc_rdata_o  = line_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cache agents, a delay-programmable memory
// and a transaction-level reference of round-robin arbitration and expected data.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ic_req_i = 1'b0, dc_req_i = 1'b0, dc_we_i = 1'b0;
    logic [31:0]  ic_addr_i = 32'h0, dc_addr_i = 32'h0;
    logic [127:0] dc_wdata_i = 128'h0, mem_rdata_i = 128'h0;
    logic         mem_ready_i = 1'b0, mem_valid_i = 1'b0;
    logic         ic_gnt_o, ic_valid_o, dc_gnt_o, dc_valid_o, mem_req_o, mem_we_o;
    logic [127:0] ic_rdata_o, dc_rdata_o, mem_wdata_o;
    logic [31:0]  mem_addr_o;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
        .ic_valid_o(ic_valid_o), .ic_rdata_o(ic_rdata_o),
        .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
        .dc_gnt_o(dc_gnt_o), .dc_valid_o(dc_valid_o), .dc_rdata_o(dc_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [31:0] addr; logic [127:0] wdata; } dreq_t;

    int compared = 0, mismatched = 0;
    // memory model
    int req_dly = 0, resp_dly = 0, m_phase = 0, m_cnt = 0, stab_err = 0;
    bit rand_dly = 1'b0;
    logic [31:0] m_addr, last_mem_addr;
    logic m_we, last_mem_we;
    logic [127:0] m_wdata, last_mem_wdata;
    logic [127:0] mem_store [logic [31:0]];
    // agents
    logic [31:0] ic_q [$];
    dreq_t dc_q [$];
    bit ic_busy = 1'b0, dc_busy = 1'b0, ic_drop = 1'b0;
    // reference model
    logic [127:0] ref_mem [logic [31:0]];
    bit ref_idle = 1'b1, ref_inflight = 1'b0, ref_reopen = 1'b0;
    int ref_last = 0, ref_owner = 0;
    logic [31:0] ref_addr;
    logic ref_we;
    logic [127:0] ref_wdata, ref_data;
    // observations
    int gnt_log [$];
    int n_ic_gnt, n_dc_gnt, n_ic_val, n_dc_val;
    logic [127:0] last_ic_rdata, last_dc_rdata;

    function automatic logic [127:0] init_line(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
    endfunction

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return {a[31:4], 4'h0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: capture what the DUT samples, then check, run memory and agents
    task automatic step();
        logic s_rst, s_ic, s_dc, s_mv, s_dc_we;
        logic [31:0] s_ic_addr, s_dc_addr;
        logic [127:0] s_dc_wdata;
        logic e_ig, e_dg, e_iv, e_dv;
        int ph0;
        @(posedge clk);
        s_rst = reset; s_ic = ic_req_i; s_dc = dc_req_i; s_mv = mem_valid_i;
        s_ic_addr = ic_addr_i; s_dc_addr = dc_addr_i; s_dc_we = dc_we_i; s_dc_wdata = dc_wdata_i;
        @(negedge clk);
        e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0;
        if (s_rst) begin
            ref_idle = 1'b1; ref_inflight = 1'b0; ref_reopen = 1'b0; ref_last = 0;
        end else if (ref_idle && (s_ic || s_dc)) begin
            ref_owner = (s_ic && s_dc) ? ((ref_last == 0) ? 1 : 0) : (s_dc ? 1 : 0);
            ref_last = ref_owner; ref_idle = 1'b0; ref_inflight = 1'b1;
            ref_addr = aligned((ref_owner == 1) ? s_dc_addr : s_ic_addr);
            ref_we = (ref_owner == 1) ? s_dc_we : 1'b0;
            ref_wdata = ref_we ? s_dc_wdata : 128'h0;
            if (ref_we) begin
                ref_data = 128'h0;
                ref_mem[ref_addr] = ref_wdata;
            end else begin
                ref_data = ref_mem.exists(ref_addr) ? ref_mem[ref_addr] : init_line(ref_addr);
            end
            e_ig = (ref_owner == 0); e_dg = (ref_owner == 1);
            chk("mem_req_with_gnt", mem_req_o, 128'd1);
        end else if (ref_inflight && s_mv) begin
            e_iv = (ref_owner == 0); e_dv = (ref_owner == 1);
            ref_inflight = 1'b0; ref_reopen = 1'b1;
        end else if (ref_reopen) begin
            ref_reopen = 1'b0; ref_idle = 1'b1;
        end
        chk("ic_gnt", ic_gnt_o, e_ig);
        chk("dc_gnt", dc_gnt_o, e_dg);
        chk("ic_valid", ic_valid_o, e_iv);
        chk("dc_valid", dc_valid_o, e_dv);
        if (e_iv) chk("ic_rdata", ic_rdata_o, ref_data);
        if (e_dv) chk("dc_rdata", dc_rdata_o, ref_data);
        if (ic_gnt_o)   begin gnt_log.push_back(0); n_ic_gnt++; end
        if (dc_gnt_o)   begin gnt_log.push_back(1); n_dc_gnt++; end
        if (ic_valid_o) begin n_ic_val++; last_ic_rdata = ic_rdata_o; end
        if (dc_valid_o) begin n_dc_val++; last_dc_rdata = dc_rdata_o; end
        // memory model
        mem_ready_i = 1'b0; mem_valid_i = 1'b0;
        ph0 = m_phase;
        if (ph0 == 0 && mem_req_o) begin
            m_addr = mem_addr_o; m_we = mem_we_o; m_wdata = mem_wdata_o;
            last_mem_addr = m_addr; last_mem_we = m_we; last_mem_wdata = m_wdata;
            chk("mem_addr", mem_addr_o, ref_addr);
            chk("mem_we", mem_we_o, ref_we);
            chk("mem_wdata", mem_wdata_o, ref_wdata);
            if (rand_dly) begin req_dly = $urandom_range(0, 3); resp_dly = $urandom_range(0, 4); end
            m_cnt = req_dly; m_phase = 1;
        end
        if (m_phase == 1) begin
            if (ph0 == 1 && (mem_req_o !== 1'b1 || mem_addr_o !== m_addr ||
                             mem_we_o !== m_we || mem_wdata_o !== m_wdata)) stab_err++;
            if (m_cnt == 0) begin
                mem_ready_i = 1'b1;
                if (m_we) mem_store[m_addr] = m_wdata;
                m_cnt = resp_dly; m_phase = 2;
            end else m_cnt--;
        end else if (m_phase == 2) begin
            if (m_cnt == 0) begin
                mem_valid_i = 1'b1;
                mem_rdata_i = m_we ? {4{$urandom()}} :
                              (mem_store.exists(m_addr) ? mem_store[m_addr] : init_line(m_addr));
                m_phase = 0;
            end else m_cnt--;
        end
        // cache agents: hold req until valid, present next request right away
        if (ic_busy && ic_valid_o) begin ic_busy = 1'b0; ic_req_i = 1'b0; end
        else if (ic_busy && ic_gnt_o && ic_drop) ic_req_i = 1'b0;
        if (!ic_busy && ic_q.size() > 0) begin
            ic_addr_i = ic_q.pop_front(); ic_req_i = 1'b1; ic_busy = 1'b1;
        end
        if (dc_busy && dc_valid_o) begin dc_busy = 1'b0; dc_req_i = 1'b0; end
        if (!dc_busy && dc_q.size() > 0) begin
            dreq_t d;
            d = dc_q.pop_front();
            dc_we_i = d.we; dc_addr_i = d.addr; dc_wdata_i = d.wdata;
            dc_req_i = 1'b1; dc_busy = 1'b1;
        end
    endtask

    task automatic drain(input int max_cycles, input string tag);
        int n = 0;
        while ((ic_q.size() > 0 || dc_q.size() > 0 || ic_busy || dc_busy ||
                ref_inflight || m_phase != 0) && n < max_cycles) begin
            step(); n++;
        end
        chk({tag, "_done"}, (n < max_cycles), 128'd1);
        step(); step();
    endtask

    task automatic rst_assert();
        reset = 1'b1;
        ic_req_i = 1'b0; dc_req_i = 1'b0; ic_busy = 1'b0; dc_busy = 1'b0;
        ic_q.delete(); dc_q.delete();
        #1;
        chk("rst_ic_gnt", ic_gnt_o, 128'd0);      chk("rst_dc_gnt", dc_gnt_o, 128'd0);
        chk("rst_ic_valid", ic_valid_o, 128'd0);  chk("rst_dc_valid", dc_valid_o, 128'd0);
        chk("rst_ic_rdata", ic_rdata_o, 128'd0);  chk("rst_dc_rdata", dc_rdata_o, 128'd0);
        chk("rst_mem_req", mem_req_o, 128'd0);    chk("rst_mem_we", mem_we_o, 128'd0);
        chk("rst_mem_addr", mem_addr_o, 128'd0);  chk("rst_mem_wdata", mem_wdata_o, 128'd0);
    endtask

    task automatic clear_counts();
        n_ic_gnt = 0; n_dc_gnt = 0; n_ic_val = 0; n_dc_val = 0; stab_err = 0;
        gnt_log.delete();
    endtask

    initial begin
        logic [127:0] a5_line, wb_line;
        int exp_order [4];
        dreq_t d;
        exp_order = '{1, 0, 1, 0};
        a5_line = {16{8'hA5}};
        wb_line = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

        // reset state
        rst_assert();
        step(); step();
        reset = 1'b0;

        // single I-fill with 5+5 cycle memory
        clear_counts();
        req_dly = 5; resp_dly = 5;
        mem_store[32'h1000] = a5_line; ref_mem[32'h1000] = a5_line;
        ic_q.push_back(32'h0000_100C);
        drain(100, "t1");
        chk("t1_mem_addr", last_mem_addr, 128'h1000);
        chk("t1_ic_gnts", n_ic_gnt, 128'd1);   chk("t1_ic_vals", n_ic_val, 128'd1);
        chk("t1_dc_gnts", n_dc_gnt, 128'd0);   chk("t1_dc_vals", n_dc_val, 128'd0);
        chk("t1_rdata", last_ic_rdata, a5_line);

        // both requesters high from reset, two transactions each
        rst_assert();
        clear_counts();
        req_dly = 0; resp_dly = 0;
        ic_q.push_back(32'h0000_0040); ic_q.push_back(32'h0000_0050);
        dc_q.push_back('{1'b0, 32'h0000_0060, 128'h0});
        dc_q.push_back('{1'b0, 32'h0000_0070, 128'h0});
        step(); step();
        reset = 1'b0;
        drain(100, "t2");
        chk("t2_grants", gnt_log.size(), 128'd4);
        for (int i = 0; i < gnt_log.size() && i < 4; i++) chk("t2_order", gnt_log[i], exp_order[i]);

        // D write-back, then read it back through the I side
        clear_counts();
        dc_q.push_back('{1'b1, 32'h0000_2000, wb_line});
        drain(100, "t3");
        chk("t3_mem_we", last_mem_we, 128'd1);
        chk("t3_mem_wdata", last_mem_wdata, wb_line);
        chk("t3_dc_vals", n_dc_val, 128'd1);
        chk("t3_dc_rdata", last_dc_rdata, 128'd0);
        ic_q.push_back(32'h0000_2008);
        drain(100, "t3r");
        chk("t3_readback", last_ic_rdata, wb_line);

        // ready held low 7 cycles with the other requester waiting
        clear_counts();
        req_dly = 7; resp_dly = 1;
        dc_q.push_back('{1'b0, 32'h0000_3004, 128'h0});
        ic_q.push_back(32'h0000_3010);
        drain(100, "t4");
        chk("t4_stable", stab_err, 128'd0);
        chk("t4_first_dc", gnt_log[0], 128'd1);
        chk("t4_grants", n_ic_gnt + n_dc_gnt, 128'd2);

        // reset in WAIT, late mem_valid must be dropped
        clear_counts();
        req_dly = 0; resp_dly = 6;
        ic_q.push_back(32'h0000_4000);
        for (int i = 0; i < 20 && m_phase != 2; i++) step();
        step(); step();
        rst_assert();
        step();
        reset = 1'b0;
        drain(50, "t5");
        chk("t5_no_ic_val", n_ic_val, 128'd0);
        chk("t5_no_dc_val", n_dc_val, 128'd0);
        dc_q.push_back('{1'b0, 32'h0000_4010, 128'h0});
        resp_dly = 1;
        drain(100, "t5n");
        chk("t5_next_gnt", n_dc_gnt, 128'd1);
        chk("t5_next_val", n_dc_val, 128'd1);

        // I drops req after grant while D is pending
        clear_counts();
        ic_drop = 1'b1; req_dly = 2; resp_dly = 2;
        ic_q.push_back(32'h0000_5000);
        dc_q.push_back('{1'b0, 32'h0000_5010, 128'h0});
        drain(100, "t6");
        ic_drop = 1'b0;
        chk("t6_ic_val", n_ic_val, 128'd1);
        chk("t6_dc_val", n_dc_val, 128'd1);
        chk("t6_first_ic", gnt_log[0], 128'd0);

        // randomized traffic with random memory latency
        clear_counts();
        rand_dly = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) ic_q.push_back(32'h0000_6000 + $urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                d.we = ($urandom_range(0, 1) == 1);
                d.addr = 32'h0000_6000 + $urandom_range(0, 255);
                d.wdata = {4{$urandom()}};
                dc_q.push_back(d);
            end
            repeat ($urandom_range(1, 8)) step();
        end
        drain(3000, "rand");
        chk("rand_ic_balance", n_ic_val, n_ic_gnt);
        chk("rand_dc_balance", n_dc_val, n_dc_gnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction cache and the data cache. Only one line-sized transaction (128-bit read fill or 128-bit write-back) is outstanding at a time. Contention is resolved round-robin. The block sits between the two cache controllers and the memory model, and carries all of the memory model's MEM_REQ_DELAY/MEM_RESP_DELAY latency.

## Interface
- ADDRESS_BITS, 32, byte address width
- CACHE_LINE_LEN, 128, line width in bits; one transaction moves one line
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- ic_req_i  in  1  I-cache line-fill request; held until ic_valid_o
- ic_addr_i  in  ADDRESS_BITS  I-cache fill address; stable while ic_req_i is high
- ic_gnt_o  out  1  one-cycle pulse: I-cache request accepted
- ic_valid_o  out  1  one-cycle pulse: ic_rdata_o is valid
- ic_rdata_o  out  CACHE_LINE_LEN  fill data
- dc_req_i  in  1  D-cache request; held until dc_valid_o
- dc_we_i  in  1  1 = write-back of dc_wdata_i, 0 = line fill
- dc_addr_i  in  ADDRESS_BITS  D-cache address
- dc_wdata_i  in  CACHE_LINE_LEN  write-back data
- dc_gnt_o  out  1  one-cycle pulse: D-cache request accepted
- dc_valid_o  out  1  one-cycle pulse: fill data valid, or write acknowledged
- dc_rdata_o  out  CACHE_LINE_LEN  fill data; 0 for writes
- mem_req_o  out  1  request to memory; held until mem_ready_i
- mem_we_o  out  1  write enable toward memory
- mem_addr_o  out  ADDRESS_BITS  line-aligned address
- mem_wdata_o  out  CACHE_LINE_LEN  write data
- mem_ready_i  in  1  memory accepts the request this cycle
- mem_valid_i  in  1  memory response or write acknowledge
- mem_rdata_i  in  CACHE_LINE_LEN  memory read data

## Operation
- FSM states: ARB_IDLE → ARB_REQ → ARB_WAIT → ARB_RESP → ARB_IDLE.
- **ARB_IDLE**
  - Samples ic_req_i and dc_req_i.
  - If only one is high, that requester wins.
  - If both are high, the winner is the requester that is not last_owner.
  - The winner is latched into owner; addr, we and wdata are latched into registers.
  - The winner's gnt_o pulses in the following cycle.
  - last_owner is updated to the winner.
  - mem_valid_i is ignored in this state.
- **ARB_REQ**
  - mem_req_o = 1 with the latched fields.
  - On mem_ready_i = 1, go to ARB_WAIT.
- **ARB_WAIT**
  - On mem_valid_i = 1, capture mem_rdata_i, or capture 0 if the latched we = 1.
  - Go to ARB_RESP.
- **ARB_RESP**
  - The owner's valid_o = 1 and rdata_o = the captured line.
  - Go to ARB_IDLE.
- I-cache transactions always have we = 0; ic_rdata_o is meaningful only while ic_valid_o is high.
- Addressing: mem_addr_o = {latched_addr[ADDRESS_BITS-1:4], 4'b0}. Requester low bits are discarded.
- If a requester drops its req after being granted, the transaction still completes and the valid pulse is still issued. The requester ignores it.
- Reset (asynchronous, also mid-transaction):
  - State → ARB_IDLE, last_owner → OWNER_IC, so the D-cache wins the first contention.
  - All outputs and data registers are 0.
  - A late mem_valid_i arriving after reset is dropped.

## Timing
- Request high at edge N in IDLE:
  - gnt_o and mem_req_o are high during cycle N+1.
  - With mem_ready_i high in N+1, the FSM is in WAIT from N+2.
- mem_valid_i at cycle M in WAIT → owner valid_o pulse in cycle M+1.
- Arbiter overhead: 1 cycle grant + 1 cycle response, plus 1 cycle back in IDLE before the next grant. Minimum request-to-valid latency is 3 cycles when the memory responds immediately.
- mem_valid_i is honoured only in ARB_WAIT. mem_ready_i is honoured only in ARB_REQ.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- gnt_o and valid_o are never high for both requesters in the same cycle.

## Structure
- Add to brisc_pkg:
  - typedef arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP}
  - typedef arb_owner_e {OWNER_IC, OWNER_DC}
  - constant LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN/BYTE_LEN)
- One sub-module, rr_arb2: a combinational two-way round-robin picker with inputs req[1:0] and last_owner, and output winner. Reused by future shared resources.

## Test plan
- Single I-fill, addr 0x0000_100C, memory returns line 0xA5…A5 after 5 + 5 cycles → mem_addr_o = 0x0000_1000, one ic_gnt_o pulse, one ic_valid_o pulse with 0xA5…A5, dc_* stays 0.
- Both requesters high from reset → D served first, then I. Both held high for 4 transactions → grant order D, I, D, I.
- D write-back, addr 0x2000, data 0x1234… → mem_we_o = 1 and mem_wdata_o matches. dc_valid_o pulses with dc_rdata_o = 0.
- mem_ready_i held low for 7 cycles in ARB_REQ → mem_req_o and latched fields stay stable throughout; no grant is issued to the other requester.
- reset asserted in ARB_WAIT, then mem_valid_i pulses → no valid_o pulse, FSM in IDLE, the next request is served normally.
- ic_req_i dropped after ic_gnt_o → transaction still completes with an ic_valid_o pulse; an already-pending dc_req_i is granted in the cycle after IDLE is re-entered.
